uart_status_tx: RTL and testbench

UART_STATUS_TX -- requirements
Module: uart_status_tx

---
 rtl/uart_status_pkg.sv | 41 ++++
 rtl/uart_status_if.sv | 21 ++
 rtl/uart_status_tx_core.sv | 79 +++++++
 rtl/uart_status_tx.sv | 120 ++++++++++++
 tb/tb_uart_status_tx.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_status_pkg.sv
// Shared definitions for the UART status reporter: frame FSM state encoding,
// fixed frame bytes and the helper that maps a snapshot to its frame bytes.
package uart_status_pkg;

    localparam int unsigned FRAME_LEN = 6;

    localparam logic [7:0] CH_F  = 8'h46;
    localparam logic [7:0] CH_C  = 8'h43;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    typedef logic [1:0] frame_state_t;

    localparam frame_state_t ST_IDLE = 2'd0;
    localparam frame_state_t ST_LOAD = 2'd1;
    localparam frame_state_t ST_SEND = 2'd2;
    localparam frame_state_t ST_NEXT = 2'd3;

    typedef struct packed {
        logic [3:0] filter;
        logic [1:0] cut;
    } status_t;

    function automatic logic [7:0] hex_ascii(input logic [3:0] v);
        return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h37 + {4'h0, v});
    endfunction

    function automatic logic [7:0] frame_byte(input logic [2:0] idx, input status_t s);
        logic [7:0] b;
        case (idx)
            3'd0:    b = CH_F;
            3'd1:    b = hex_ascii(s.filter);
            3'd2:    b = CH_C;
            3'd3:    b = 8'h30 + {6'h00, s.cut};
            3'd4:    b = CH_CR;
            default: b = CH_LF;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_status_if.sv
// Status-reporter signal bundle: oversample tick, status inputs, query and
// the serial line with its busy/done flags.
interface uart_status_if;
    logic       br_tick;
    logic [3:0] filter_sel;
    logic [1:0] cut_sel;
    logic       query;
    logic       tx;
    logic       tx_busy;
    logic       frame_done;

    modport master (
        output br_tick, filter_sel, cut_sel, query,
        input  tx, tx_busy, frame_done
    );

    modport slave (
        input  br_tick, filter_sel, cut_sel, query,
        output tx, tx_busy, frame_done
    );
endinterface

// File: rtl/uart_status_tx_core.sv
// uart_tx_core: 8N1 serializer, LSB first, each bit held for OVERSAMPLE
// br_tick pulses; done is a one-clk pulse as the stop bit completes.
module uart_tx_core #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       br_tick,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o
);
    localparam int unsigned TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

    logic          busy_q, busy_d;
    logic          tx_q, tx_d;
    logic [8:0]    sh_q, sh_d;
    logic [3:0]    bit_q, bit_d;
    logic [TW-1:0] tick_q, tick_d;
    logic          bit_end;

    assign bit_end = busy_q && br_tick && (tick_q == TICK_LAST);
    // Combinational done lets the frame FSM react in the same cycle, keeping
    // the inter-byte gap down to two clocks.
    assign done_o  = bit_end && (bit_q == 4'd9);
    assign tx_o    = tx_q;
    assign busy_o  = busy_q;

    always_comb begin
        busy_d = busy_q;
        tx_d   = tx_q;
        sh_d   = sh_q;
        bit_d  = bit_q;
        tick_d = tick_q;
        if (!busy_q) begin
            if (start_i) begin
                busy_d = 1'b1;
                tx_d   = 1'b0;
                sh_d   = {1'b1, data_i};
                bit_d  = 4'd0;
                tick_d = '0;
            end
        end else if (br_tick) begin
            if (tick_q == TICK_LAST) begin
                tick_d = '0;
                if (bit_q == 4'd9) begin
                    busy_d = 1'b0;
                    tx_d   = 1'b1;
                end else begin
                    tx_d  = sh_q[0];
                    sh_d  = {1'b1, sh_q[8:1]};
                    bit_d = bit_q + 4'd1;
                end
            end else begin
                tick_d = tick_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            tx_q   <= 1'b1;
            sh_q   <= '1;
            bit_q  <= '0;
            tick_q <= '0;
        end else begin
            busy_q <= busy_d;
            tx_q   <= tx_d;
            sh_q   <= sh_d;
            bit_q  <= bit_d;
            tick_q <= tick_d;
        end
    end

endmodule

// File: rtl/uart_status_tx.sv
// uart_status_tx: on query, serializes "F<hex filter>C<cut>\r\n" from a snapshot.
// Build option UART_STATUS_AUTO_EN: a change of {filter_sel,cut_sel} also triggers.
module uart_status_tx
    import uart_status_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 16
) (
    input logic          clk,
    input logic          reset,
    uart_status_if.slave bus
);
    frame_state_t state_q, state_d;
    logic [2:0]   idx_q, idx_d;
    status_t      snap_q, snap_d;
    logic         pend_q, pend_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    status_t      cur;
    logic         trigger;
    logic         core_start;
    logic [7:0]   core_data;
    logic         core_tx;
    logic         core_busy;
    logic         core_done;

    assign cur = {bus.filter_sel, bus.cut_sel};

`ifdef UART_STATUS_AUTO_EN
    status_t last_q, last_d;
    assign trigger = bus.query || (cur != last_q);
`else
    assign trigger = bus.query;
`endif

    assign core_start = (state_q == ST_LOAD) && !core_busy;
    assign core_data  = frame_byte(idx_q, snap_q);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        pend_d  = pend_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef UART_STATUS_AUTO_EN
        last_d  = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (trigger || pend_q) begin
                    snap_d  = cur;
                    pend_d  = 1'b0;
                    idx_d   = 3'd0;
                    busy_d  = 1'b1;
                    state_d = ST_LOAD;
`ifdef UART_STATUS_AUTO_EN
                    last_d  = cur;
`endif
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_LOAD: if (core_start) state_d = ST_SEND;
            ST_SEND: if (core_done) state_d = ST_NEXT;
            default: begin
                if (idx_q < 3'(FRAME_LEN - 1)) begin
                    idx_d   = idx_q + 3'd1;
                    state_d = ST_LOAD;
                end else begin
                    idx_d   = 3'd0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
        endcase
        // Triggers while a frame is in flight collapse into one pending frame.
        if (trigger && (state_q != ST_IDLE)) pend_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            snap_q  <= '0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_STATUS_AUTO_EN
            last_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_STATUS_AUTO_EN
            last_q  <= last_d;
`endif
        end
    end

    uart_tx_core #(.OVERSAMPLE(OVERSAMPLE)) u_core (
        .clk     (clk),
        .reset   (reset),
        .br_tick (bus.br_tick),
        .start_i (core_start),
        .data_i  (core_data),
        .tx_o    (core_tx),
        .busy_o  (core_busy),
        .done_o  (core_done)
    );

    assign bus.tx         = core_tx;
    assign bus.tx_busy    = busy_q;
    assign bus.frame_done = done_q;

endmodule

// File: tb/tb_uart_status_tx.sv
// Scoreboard bench for uart_status_tx: a line receiver decodes tx and checks
// each byte against frames predicted from the status inputs at trigger time.
module tb_uart_status_tx;

    localparam int OS     = 16;
    localparam int P      = 2;
    localparam int BIT    = OS * P;
    localparam int STOP_N = 9 * BIT + BIT / 2;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    uart_status_if bus();

    uart_status_tx #(.OVERSAMPLE(OS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  exp_q[$];
    int          exp_frames = 0;
    int          got_frames = 0;
    int          rx_cnt = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, cyc);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic logic [7:0] hex_char(input int v);
        return (v < 10) ? 8'(48 + v) : 8'(65 + v - 10);
    endfunction

    task automatic push_frame(input int f, input int c);
        exp_q.push_back(8'h46);
        exp_q.push_back(hex_char(f));
        exp_q.push_back(8'h43);
        exp_q.push_back(8'(48 + c));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        exp_frames++;
    endtask

    // Start bit plus the run of low data bits from the LSB end.
    function automatic int low_run_bits(input logic [7:0] e);
        int k = 1;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) break;
            k++;
        end
        return k;
    endfunction

    initial begin
        bus.br_tick = 1'b0;
        forever begin
            repeat (P - 1) @(negedge clk);
            bus.br_tick = 1'b1;
            @(negedge clk);
            bus.br_tick = 1'b0;
        end
    end

    // Line receiver / scoreboard consumer.
    initial begin
        logic [7:0] d;
        logic       stop;
        logic       low;
        logic       aborted;
        int         run;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!reset && bus.tx === 1'b0) begin
                d = '0; stop = 1'b0; low = 1'b1; run = 1; aborted = 1'b0;
                for (int n = 1; n <= STOP_N; n++) begin
                    @(negedge clk);
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (low) begin
                        if (bus.tx === 1'b0) run++;
                        else low = 1'b0;
                    end
                    if ((n % BIT) == BIT / 2 && n / BIT >= 1 && n / BIT <= 8)
                        d[(n / BIT) - 1] = bus.tx;
                    if (n == STOP_N) stop = bus.tx;
                end
                if (!aborted) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected rx byte", int'(d), -1);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx byte", int'(d), int'(e));
                        check("stop bit", int'(stop), 1);
                        check_range("low run length", run,
                                    low_run_bits(e) * BIT - P, low_run_bits(e) * BIT + P);
                    end
                    rx_cnt++;
                end
            end
        end
    end

    initial begin
        logic prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.frame_done === 1'b1) begin
                got_frames++;
                check("frame_done single pulse", int'(prev), 0);
                check("tx_busy during frame_done", int'(bus.tx_busy), 1);
            end
            prev = bus.frame_done;
        end
    end

    task automatic do_query();
        @(negedge clk);
        bus.query = 1'b1;
        @(negedge clk);
        bus.query = 1'b0;
    endtask

    task automatic set_in(input int f, input int c);
        bus.filter_sel = 4'(f);
        bus.cut_sel    = 2'(c);
    endtask

    task automatic wait_idle(input string name);
        int w = 0;
        int quiet = 0;
        while (quiet < 8 && w < 20000) begin
            @(negedge clk);
            w++;
            if (bus.tx_busy === 1'b0 && bus.tx === 1'b1) quiet++;
            else quiet = 0;
        end
        check({name, " idle timeout"}, int'(quiet >= 8), 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, w, lows, busys, base, f, c, f2, c2;
        reset = 1'b1;
        bus.query = 1'b0;
        set_in(0, 0);
        repeat (3) @(negedge clk);
        check("reset tx", int'(bus.tx), 1);
        check("reset tx_busy", int'(bus.tx_busy), 0);
        check("reset frame_done", int'(bus.frame_done), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("idle tx", int'(bus.tx), 1);

        // Basic frame plus timing: 60 bit times, busy falls after frame_done.
        set_in(3, 1);
        push_frame(3, 1);
        do_query();
        w = 0;
        while (bus.tx !== 1'b0 && w < 200) begin @(negedge clk); w++; end
        check("start bit seen", int'(w < 200), 1);
        t0 = cyc;
        w = 0;
        while (bus.frame_done !== 1'b1 && w < 5000) begin @(negedge clk); w++; end
        check("frame_done seen", int'(w < 5000), 1);
        t1 = cyc;
        check_range("frame duration", t1 - t0, 60 * BIT - 7 * P, 60 * BIT + 6 * P + 20);
        @(negedge clk);
        check("tx_busy drops after frame_done", int'(bus.tx_busy), 0);
        wait_idle("frame1");

        set_in(11, 2);
        push_frame(11, 2);
        do_query();
        wait_idle("frame hex B");

        // Mid-frame change and repeated queries: one extra frame with new value.
        set_in(0, 0);
        push_frame(0, 0);
        do_query();
        repeat (200) @(negedge clk);
        set_in(7, 0);
        repeat (3) begin do_query(); repeat (2) @(negedge clk); end
        push_frame(7, 0);
        wait_idle("pending frame");
        check("frames after pending", got_frames, exp_frames);

        // Status change while idle, no query.
        set_in(7, 2);
`ifdef UART_STATUS_AUTO_EN
        push_frame(7, 2);
        repeat (4) @(negedge clk);
        wait_idle("auto frame");
`else
        lows = 0;
        repeat (600) begin @(negedge clk); if (bus.tx !== 1'b1) lows++; end
        check("no frame without query", lows, 0);
`endif

        for (int it = 0; it < 5; it++) begin
            f = int'($urandom_range(0, 15));
            c = int'($urandom_range(0, 3));
            set_in(f, c);
            push_frame(f, c);
            do_query();
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(50, 1500)) @(negedge clk);
                f2 = int'($urandom_range(0, 15));
                c2 = int'($urandom_range(0, 3));
                set_in(f2, c2);
                repeat ($urandom_range(1, 3)) begin do_query(); @(negedge clk); end
                push_frame(f2, c2);
            end
            wait_idle("random frame");
        end
        check("frame count", got_frames, exp_frames);

        // Reset in the middle of byte 3.
        set_in(5, 3);
        push_frame(5, 3);
        base = rx_cnt;
        do_query();
        w = 0;
        while (rx_cnt < base + 3 && w < 5000) begin @(negedge clk); w++; end
        check("three bytes before reset", rx_cnt - base, 3);
        repeat (40) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("tx high on async reset", int'(bus.tx), 1);
        check("tx_busy low on async reset", int'(bus.tx_busy), 0);
        exp_q.delete();
        exp_frames--;
        repeat (3) @(negedge clk);
        set_in(0, 0);
        @(negedge clk);
        reset = 1'b0;
        lows = 0;
        busys = 0;
        repeat (3000) begin
            @(negedge clk);
            if (bus.tx !== 1'b1) lows++;
            if (bus.tx_busy !== 1'b0) busys++;
        end
        check("no tx after reset release", lows, 0);
        check("no busy after reset release", busys, 0);
        check("final frame count", got_frames, exp_frames);
        check("scoreboard drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
